// File: rtl/fm_spy_ring.sv
// Spy buffer for one fast-monitoring channel: arm/trigger capture with a post-trigger
// window, software freeze, random-access readout and one-shot or looping playback.
module fm_spy_ring #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk_hs,
  input  logic              rst_hs,
  input  logic [DATA_W-1:0] mon_data,
  input  logic              mon_valid,
  input  logic              arm,
  input  logic              trigger,
  input  logic              sw_freeze,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [1:0]        playback_mode,
  input  logic              pb_start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] pb_data,
  output logic              pb_valid,
  output logic              pb_last,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] trig_ptr,
  output logic              wrapped,
  output logic              frozen
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_POST     = 3'd2,
    S_FROZEN   = 3'd3,
    S_PLAYBACK = 3'd4
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
  logic              wrapped_q, wrapped_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [ADDR_W-1:0] pb_addr_q, pb_addr_d;
  logic [ADDR_W-1:0] pb_idx_q, pb_idx_d;
  logic              rd_valid_q, rd_valid_d;
  logic              pb_valid_q, pb_valid_d;
  logic              pb_last_q, pb_last_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] pb_data_q;

  logic              we_s;
  logic              rd_hon_s;
  logic [ADDR_W-1:0] raddr_s;
  logic [ADDR_W-1:0] oldest_s;
  logic [ADDR_W-1:0] last_idx_s;
  logic              empty_s;
  logic              mode_run_s;

  // Playback window derived from the capture pointers, which are stable once frozen.
  assign oldest_s   = wrapped_q ? wr_ptr_q : {ADDR_W{1'b0}};
  assign last_idx_s = wrapped_q ? {ADDR_W{1'b1}} : (wr_ptr_q - ADDR_W'(1));
  assign empty_s    = !wrapped_q && (wr_ptr_q == {ADDR_W{1'b0}});
  assign mode_run_s = (playback_mode == 2'b01) || (playback_mode == 2'b10);

  // Next-state logic: capture control, readout arbitration and playback sequencing.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    wrapped_d  = wrapped_q;
    remain_d   = remain_q;
    pb_addr_d  = pb_addr_q;
    pb_idx_d   = pb_idx_q;
    pb_valid_d = 1'b0;
    pb_last_d  = 1'b0;
    we_s       = 1'b0;
    rd_hon_s   = 1'b0;
    raddr_s    = rd_addr;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d    = S_ARMED;
          wr_ptr_d   = {ADDR_W{1'b0}};
          trig_ptr_d = {ADDR_W{1'b0}};
          wrapped_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (arm) begin
          wr_ptr_d   = {ADDR_W{1'b0}};
          trig_ptr_d = {ADDR_W{1'b0}};
          wrapped_d  = 1'b0;
        end else if (sw_freeze) begin
          state_d    = S_FROZEN;
          trig_ptr_d = wr_ptr_q;
        end else if (trigger) begin
          trig_ptr_d = wr_ptr_q;
          if (post_count == {ADDR_W{1'b0}}) begin
            state_d = S_FROZEN;
          end else if (mon_valid) begin
            // The trigger-cycle word is the first post-trigger word.
            we_s     = 1'b1;
            remain_d = post_count - ADDR_W'(1);
            state_d  = (post_count == ADDR_W'(1)) ? S_FROZEN : S_POST;
          end else begin
            remain_d = post_count;
            state_d  = S_POST;
          end
        end else begin
          we_s = mon_valid;
        end
      end
      S_POST: begin
        if (arm) begin
          state_d    = S_ARMED;
          wr_ptr_d   = {ADDR_W{1'b0}};
          trig_ptr_d = {ADDR_W{1'b0}};
          wrapped_d  = 1'b0;
        end else if (sw_freeze) begin
          state_d = S_FROZEN;
        end else if (mon_valid) begin
          we_s     = 1'b1;
          remain_d = remain_q - ADDR_W'(1);
          state_d  = (remain_q == ADDR_W'(1)) ? S_FROZEN : S_POST;
        end else begin
          state_d = S_POST;
        end
      end
      S_FROZEN: begin
        if (arm) begin
          state_d    = S_ARMED;
          wr_ptr_d   = {ADDR_W{1'b0}};
          trig_ptr_d = {ADDR_W{1'b0}};
          wrapped_d  = 1'b0;
        end else begin
          rd_hon_s = rd_en;
          if (pb_start && mode_run_s && !empty_s) begin
            state_d   = S_PLAYBACK;
            pb_addr_d = oldest_s;
            pb_idx_d  = {ADDR_W{1'b0}};
          end else begin
            state_d = S_FROZEN;
          end
        end
      end
      S_PLAYBACK: begin
        if (arm) begin
          state_d    = S_ARMED;
          wr_ptr_d   = {ADDR_W{1'b0}};
          trig_ptr_d = {ADDR_W{1'b0}};
          wrapped_d  = 1'b0;
        end else if (pb_start || !mode_run_s) begin
          state_d = S_FROZEN;
        end else begin
          raddr_s    = pb_addr_q;
          pb_valid_d = 1'b1;
          pb_last_d  = (pb_idx_q == last_idx_s);
          if (pb_idx_q == last_idx_s) begin
            // Loop mode restarts at the oldest word with no bubble.
            pb_addr_d = oldest_s;
            pb_idx_d  = {ADDR_W{1'b0}};
            state_d   = (playback_mode == 2'b10) ? S_PLAYBACK : S_FROZEN;
          end else begin
            pb_addr_d = pb_addr_q + ADDR_W'(1);
            pb_idx_d  = pb_idx_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (we_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (wr_ptr_q == {ADDR_W{1'b1}}) begin
        wrapped_d = 1'b1;
      end else begin
        wrapped_d = wrapped_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_d;
    end

    rd_valid_d = rd_hon_s;
  end

  // Capture RAM write port; contents are not reset.
  always_ff @(posedge clk_hs) begin
    if (!rst_hs && we_s) begin
      mem[wr_ptr_q] <= mon_data;
    end
  end

  // Control registers and registered read outputs.
  always_ff @(posedge clk_hs) begin
    if (rst_hs) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= {ADDR_W{1'b0}};
      trig_ptr_q <= {ADDR_W{1'b0}};
      wrapped_q  <= 1'b0;
      remain_q   <= {ADDR_W{1'b0}};
      pb_addr_q  <= {ADDR_W{1'b0}};
      pb_idx_q   <= {ADDR_W{1'b0}};
      rd_valid_q <= 1'b0;
      pb_valid_q <= 1'b0;
      pb_last_q  <= 1'b0;
      rd_data_q  <= {DATA_W{1'b0}};
      pb_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      wrapped_q  <= wrapped_d;
      remain_q   <= remain_d;
      pb_addr_q  <= pb_addr_d;
      pb_idx_q   <= pb_idx_d;
      rd_valid_q <= rd_valid_d;
      pb_valid_q <= pb_valid_d;
      pb_last_q  <= pb_last_d;
      if (rd_hon_s) begin
        rd_data_q <= mem[raddr_s];
      end
      if (pb_valid_d) begin
        pb_data_q <= mem[raddr_s];
      end
    end
  end

  assign state    = state_q;
  assign wr_ptr   = wr_ptr_q;
  assign trig_ptr = trig_ptr_q;
  assign wrapped  = wrapped_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign pb_valid = pb_valid_q;
  assign pb_last  = pb_last_q;
  assign pb_data  = pb_data_q;
  assign frozen   = (state_q == S_FROZEN) || (state_q == S_PLAYBACK);

endmodule

// File: tb/tb_fm_spy_ring.sv
// Directed bench for fm_spy_ring with DATA_W=16, ADDR_W=4.
module tb_fm_spy_ring;

  logic        clk_hs = 1'b0;
  logic        rst_hs;
  logic [15:0] mon_data;
  logic        mon_valid;
  logic        arm;
  logic        trigger;
  logic        sw_freeze;
  logic [3:0]  post_count;
  logic [1:0]  playback_mode;
  logic        pb_start;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [15:0] pb_data;
  logic        pb_valid;
  logic        pb_last;
  logic [2:0]  state;
  logic [3:0]  wr_ptr;
  logic [3:0]  trig_ptr;
  logic        wrapped;
  logic        frozen;

  int checks   = 0;
  int failures = 0;

  fm_spy_ring #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk_hs(clk_hs), .rst_hs(rst_hs), .mon_data(mon_data), .mon_valid(mon_valid),
    .arm(arm), .trigger(trigger), .sw_freeze(sw_freeze), .post_count(post_count),
    .playback_mode(playback_mode), .pb_start(pb_start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .pb_data(pb_data), .pb_valid(pb_valid),
    .pb_last(pb_last), .state(state), .wr_ptr(wr_ptr), .trig_ptr(trig_ptr),
    .wrapped(wrapped), .frozen(frozen)
  );

  always #5 clk_hs = ~clk_hs;

  task automatic cyc();
    @(posedge clk_hs);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  initial begin
    rst_hs = 1'b1; mon_data = 16'd0; mon_valid = 1'b0; arm = 1'b0; trigger = 1'b0;
    sw_freeze = 1'b0; post_count = 4'd0; playback_mode = 2'b00; pb_start = 1'b0;
    rd_en = 1'b0; rd_addr = 4'd0;
    cyc(); cyc();
    rst_hs = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_trig_ptr", 32'(trig_ptr), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    chk("rst_frozen", 32'(frozen), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_pb_valid", 32'(pb_valid), 32'd0);
    chk("rst_pb_last", 32'(pb_last), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_pb_data", 32'(pb_data), 32'd0);

    // arm + trigger together in IDLE: arm only
    arm = 1'b1; trigger = 1'b1; post_count = 4'd5;
    cyc();
    arm = 1'b0; trigger = 1'b0;
    chk("armtrig_state", 32'(state), 32'd1);
    chk("armtrig_trig_ptr", 32'(trig_ptr), 32'd0);
    sw_freeze = 1'b1;
    cyc();
    sw_freeze = 1'b0;
    chk("empty_frz_state", 32'(state), 32'd3);
    chk("empty_frz_wr_ptr", 32'(wr_ptr), 32'd0);
    playback_mode = 2'b01; pb_start = 1'b1;
    cyc();
    pb_start = 1'b0;
    chk("empty_pb_ignored", 32'(state), 32'd3);
    cyc();
    chk("empty_pb_valid", 32'(pb_valid), 32'd0);
    playback_mode = 2'b00;

    // scenario 1: 10 words, trigger post_count=3 on words 10..12
    do_arm();
    chk("s1_armed", 32'(state), 32'd1);
    mon_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mon_data = 16'(i);
      cyc();
    end
    trigger = 1'b1; post_count = 4'd3; mon_data = 16'd10;
    cyc();
    trigger = 1'b0;
    chk("s1_post_state", 32'(state), 32'd2);
    chk("s1_post_wr_ptr", 32'(wr_ptr), 32'd11);
    mon_data = 16'd11; cyc();
    mon_data = 16'd12; cyc();
    mon_data = 16'd99;
    chk("s1_state", 32'(state), 32'd3);
    chk("s1_frozen", 32'(frozen), 32'd1);
    chk("s1_trig_ptr", 32'(trig_ptr), 32'd10);
    chk("s1_wr_ptr", 32'(wr_ptr), 32'd13);
    chk("s1_wrapped", 32'(wrapped), 32'd0);
    cyc();
    mon_valid = 1'b0;
    chk("s1_nowrite_frozen", 32'(wr_ptr), 32'd13);
    rd_en = 1'b1;
    for (int a = 0; a < 13; a++) begin
      rd_addr = 4'(a);
      cyc();
      chk("s1_rd_valid", 32'(rd_valid), 32'd1);
      chk("s1_rd_data", 32'(rd_data), 32'(a));
    end
    rd_en = 1'b0;
    cyc();
    chk("s1_rd_idle", 32'(rd_valid), 32'd0);

    // loop playback over scenario 1
    playback_mode = 2'b10; pb_start = 1'b1;
    cyc();
    pb_start = 1'b0;
    chk("loop_state", 32'(state), 32'd4);
    chk("loop_first_gap", 32'(pb_valid), 32'd0);
    for (int k = 0; k < 30; k++) begin
      cyc();
      chk("loop_pb_valid", 32'(pb_valid), 32'd1);
      chk("loop_pb_data", 32'(pb_data), 32'(k % 13));
      chk("loop_pb_last", 32'(pb_last), ((k % 13) == 12) ? 32'd1 : 32'd0);
    end
    pb_start = 1'b1;
    cyc();
    pb_start = 1'b0;
    chk("loop_stop_state", 32'(state), 32'd3);
    chk("loop_stop_valid", 32'(pb_valid), 32'd0);
    playback_mode = 2'b00;

    // sw_freeze in POST with remaining 2
    do_arm();
    mon_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mon_data = 16'(100 + i);
      cyc();
    end
    trigger = 1'b1; post_count = 4'd4; mon_data = 16'd105;
    cyc();
    trigger = 1'b0; mon_data = 16'd106;
    cyc();
    sw_freeze = 1'b1; mon_data = 16'd107;
    cyc();
    sw_freeze = 1'b0; mon_valid = 1'b0;
    chk("swf_state", 32'(state), 32'd3);
    chk("swf_wr_ptr", 32'(wr_ptr), 32'd7);
    chk("swf_trig_ptr", 32'(trig_ptr), 32'd5);
    rd_en = 1'b1; rd_addr = 4'd6;
    cyc();
    chk("swf_rd6", 32'(rd_data), 32'd106);
    rd_addr = 4'd7;
    cyc();
    rd_en = 1'b0;
    chk("swf_rd7_unwritten", 32'(rd_data), 32'd7);

    // trigger with post_count=0
    do_arm();
    mon_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mon_data = 16'(200 + i);
      cyc();
    end
    trigger = 1'b1; post_count = 4'd0; mon_data = 16'd203;
    cyc();
    trigger = 1'b0; mon_valid = 1'b0;
    chk("pc0_state", 32'(state), 32'd3);
    chk("pc0_wr_ptr", 32'(wr_ptr), 32'd3);
    chk("pc0_trig_ptr", 32'(trig_ptr), 32'd3);
    rd_en = 1'b1; rd_addr = 4'd3;
    cyc();
    rd_en = 1'b0;
    chk("pc0_rd3_unwritten", 32'(rd_data), 32'd103);

    // scenario 2: wrap, then single-pass playback
    do_arm();
    mon_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mon_data = 16'(i);
      cyc();
    end
    trigger = 1'b1; post_count = 4'd4; mon_data = 16'd40;
    cyc();
    trigger = 1'b0;
    for (int i = 41; i < 44; i++) begin
      mon_data = 16'(i);
      cyc();
    end
    mon_valid = 1'b0;
    chk("s2_state", 32'(state), 32'd3);
    chk("s2_wrapped", 32'(wrapped), 32'd1);
    chk("s2_wr_ptr", 32'(wr_ptr), 32'd12);
    chk("s2_trig_ptr", 32'(trig_ptr), 32'd8);
    playback_mode = 2'b01; pb_start = 1'b1;
    cyc();
    pb_start = 1'b0;
    chk("s2_pb_state", 32'(state), 32'd4);
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("s2_pb_valid", 32'(pb_valid), 32'd1);
      chk("s2_pb_data", 32'(pb_data), 32'(28 + k));
      chk("s2_pb_last", 32'(pb_last), (k == 15) ? 32'd1 : 32'd0);
    end
    chk("s2_end_state", 32'(state), 32'd3);
    cyc();
    chk("s2_end_valid", 32'(pb_valid), 32'd0);
    chk("s2_end_last", 32'(pb_last), 32'd0);

    // reset during playback
    playback_mode = 2'b10; pb_start = 1'b1;
    cyc();
    pb_start = 1'b0;
    cyc(); cyc();
    chk("rstpb_pre_valid", 32'(pb_valid), 32'd1);
    rst_hs = 1'b1;
    cyc();
    rst_hs = 1'b0;
    chk("rstpb_state", 32'(state), 32'd0);
    chk("rstpb_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rstpb_trig_ptr", 32'(trig_ptr), 32'd0);
    chk("rstpb_wrapped", 32'(wrapped), 32'd0);
    chk("rstpb_frozen", 32'(frozen), 32'd0);
    chk("rstpb_rd_valid", 32'(rd_valid), 32'd0);
    chk("rstpb_rd_data", 32'(rd_data), 32'd0);
    chk("rstpb_pb_valid", 32'(pb_valid), 32'd0);
    chk("rstpb_pb_last", 32'(pb_last), 32'd0);
    chk("rstpb_pb_data", 32'(pb_data), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm_spy_ring.md
# fm_spy_ring

Parametrised single-clock spy buffer with trigger, programmable post-trigger depth and replay for one fast-monitoring channel. It generalises the per-superblock spy memory: configurable data width and depth, arm/trigger capture with a post-trigger window, software freeze, a random-access readout port, and a one-shot or looping playback stream. One instance sits per monitored channel inside the fast-monitoring data path on `clk_hs`.

## Interface
- `DATA_W`, 64, monitored word width in bits
- `ADDR_W`, 10, buffer address width; depth `DEPTH = 2**ADDR_W`
- `clk_hs` in 1, system clock; all logic single-clock
- `rst_hs` in 1, synchronous, active-high reset
- `mon_data` in DATA_W, monitored word
- `mon_valid` in 1, `mon_data` qualifier
- `arm` in 1, pulse: clear and start capture
- `trigger` in 1, pulse: start post-trigger window
- `sw_freeze` in 1, level: freeze immediately
- `post_count` in ADDR_W, words to capture from the trigger, sampled on the trigger
- `playback_mode` in 2, 00 off, 01 single pass, 10 loop, 11 treated as 00
- `pb_start` in 1, pulse: start playback, or stop it if running
- `rd_en` in 1, random read request
- `rd_addr` in ADDR_W, random read address
- `rd_data` out DATA_W, random read data
- `rd_valid` out 1, `rd_data` qualifier
- `pb_data` out DATA_W, playback word
- `pb_valid` out 1, `pb_data` qualifier
- `pb_last` out 1, marks the last word of a pass
- `state` out 3, 0 IDLE, 1 ARMED, 2 POST, 3 FROZEN, 4 PLAYBACK
- `wr_ptr` out ADDR_W, next write address
- `trig_ptr` out ADDR_W, address of the first post-trigger word
- `wrapped` out 1, buffer has wrapped since arm
- `frozen` out 1, high in FROZEN and PLAYBACK

## Operation
- **Memory**
  - Simple dual-port RAM of DEPTH x DATA_W.
  - Write port is used only in ARMED and POST, when `mon_valid` is high.
  - Each write increments `wr_ptr` modulo DEPTH. A write at DEPTH-1 sets `wrapped`.
- **IDLE**
  - Only `arm` is honoured. It moves the block to ARMED and clears `wr_ptr`, `wrapped` and `trig_ptr`.
- **ARMED**
  - Writes every valid word.
  - `sw_freeze` moves the block to FROZEN with `trig_ptr` = `wr_ptr`. The word offered in that cycle is not written.
  - `trigger` loads `trig_ptr` = `wr_ptr` and sets remaining = `post_count`.
    - If `post_count` = 0, the block goes to FROZEN and the word in that cycle is not written.
    - Otherwise the block goes to POST. A word valid in the trigger cycle is written and counts as the first post-trigger word.
- **POST**
  - Each written word decrements remaining. The write that brings remaining to 0 moves the block to FROZEN.
  - `sw_freeze` moves the block to FROZEN immediately.
  - `trigger` is ignored.
- **FROZEN**
  - No writes.
  - `rd_en` is honoured.
  - `arm` moves the block to ARMED as from IDLE.
  - `pb_start` with mode 01 or 10 moves the block to PLAYBACK when the buffer is non-empty. The buffer is empty when `wrapped` = 0 and `wr_ptr` = 0; `pb_start` is then ignored.
- **PLAYBACK**
  - Start address is oldest = `wrapped` ? `wr_ptr` : 0.
  - Word count is `wrapped` ? DEPTH : `wr_ptr`.
  - Reads one word per cycle, addresses incrementing modulo DEPTH. There is no backpressure.
  - `pb_last` is asserted with the final word of each pass.
  - Mode 01: after the last read is issued, the block returns to FROZEN.
  - Mode 10: the read after the last word restarts at oldest with no gap.
  - `pb_start`, `arm`, or mode changing to 00/11 stop playback: the block returns to FROZEN, then `arm` acts as in FROZEN. Read data already in flight still emerges.
  - `rd_en` is ignored.
- **Priority within one cycle**
  - `arm` has the highest priority.
  - Then `sw_freeze`, then `trigger`.
  - In IDLE, `arm` and `trigger` together: arm only.
- `frozen` is a pure decode of `state`.

## Timing
- **Reset:** state IDLE. `wr_ptr`, `trig_ptr`, `wrapped`, `rd_valid`, `pb_valid`, `pb_last` and `frozen` are 0. `rd_data` and `pb_data` are 0. RAM contents are undefined.
- **Writes:** a word presented at cycle t is in RAM at t+1. `wr_ptr` updates at t+1.
- **Random read:** `rd_en` at cycle t gives `rd_valid` and `rd_data` at t+1. Only the last cycle's request is relevant; there is no queue. `rd_valid` is 0 whenever the request was not honoured.
- **Playback:** `pb_start` at t gives state PLAYBACK at t+1, first `pb_valid` at t+2, then one word per cycle.
  - `pb_valid` stays high continuously in loop mode.
- **State changes:** take effect on the next edge. `state` is registered.

## Test plan
Bench parameters: DATA_W=16, ADDR_W=4 (DEPTH=16).
- Arm, then 10 valid words 0..9, then `trigger` with `post_count`=3 while words 10,11,12 are valid. Expect FROZEN, `trig_ptr`=10, `wr_ptr`=13, `wrapped`=0. `rd_addr` 0..12 returns 0..12.
- Arm, then 40 words 0..39, then `trigger` with `post_count`=4 on words 40..43. Expect `wrapped`=1 and `wr_ptr`=12. Mode 01 playback yields 28..43 in order, 16 words, `pb_last` on 43, then FROZEN.
- Mode 10 after scenario 1: `pb_valid` stays high. The sequence is 0..12,0..12…, with `pb_last` on every 12. A second `pb_start` returns to FROZEN.
- `sw_freeze` during POST with remaining 2: stops immediately, the word in that cycle is not written. `trigger` with `post_count`=0: word not written, FROZEN next cycle.
- `arm` together with `trigger` in IDLE: expect ARMED only, state 1 and `trig_ptr`=0. `pb_start` on an empty FROZEN buffer: ignored. `rst_hs` during PLAYBACK: all outputs zero next cycle.
